// File: rtl/wbm_cmd_master.sv
// Command-to-Wishbone classic initiator: one bus cycle per accepted command, response held until taken.
// Optional ack timeout (counter, error response) is built when WBM_TIMEOUT_EN is defined.
module wbm_cmd_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_DEAD
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef WBM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 32'(TIMEOUT)};
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
`ifdef WBM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
`ifdef WBM_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end
`ifdef WBM_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          rsp_dat_d = ERR_DATA;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
`ifdef WBM_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_dat   = rsp_dat_q;
`ifdef WBM_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: doc/wbm_cmd_master.md
WBM_CMD_MASTER -- requirements
Module: wbm_cmd_master

Interface
REQ-001 Parameter: TIMEOUT, default 255, max bus cycles spent waiting for ack before abort (1..65535).
REQ-002 Parameter: ERR_DATA, default 32'hDEAD_DEAD, rsp_dat value returned on timeout.
REQ-003 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high at an edge.
REQ-006 cmd_we  in  1,  cmd_sel  in  4,  cmd_adr  in  32,  cmd_dat  in  32  command fields: write flag, byte selects, address, write data.
REQ-007 rsp_valid  out  1,  rsp_ready  in  1  response handshake; rsp_dat  out  32  read data; rsp_err  out  1  timeout flag.
REQ-008 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each;  wbm_sel_o  out  4;  wbm_adr_o, wbm_dat_o  out  32  classic Wishbone initiator outputs, all registered.
REQ-009 wbm_ack_i  in  1,  wbm_dat_i  in  32  responder ack and read data.
REQ-010 busy  out  1  high whenever state != IDLE.

Function
REQ-011 FSM states IDLE, BUS, RESP; cmd_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-012 IDLE: on cmd_valid&cmd_ready at edge N, latch cmd fields onto wbm_we_o/sel_o/adr_o/dat_o, set cyc_o=stb_o=1, clear timeout counter, go BUS; cyc/stb visible from cycle N+1.
REQ-013 BUS: cyc/stb/we/sel/adr/dat held stable until termination.
REQ-014 BUS: wbm_ack_i sampled high at edge M -> cyc_o=stb_o=0 from cycle M+1; rsp_dat = wbm_dat_i if read, 32'h0 if write; rsp_err=0; go RESP.
REQ-015 Minimum command-to-response latency 2 cycles (accept edge N, ack at N+1, rsp_valid at N+2).
REQ-016 BUS: counter increments each cycle without ack; when counter reaches TIMEOUT-1 with no ack -> cyc/stb drop, rsp_dat=ERR_DATA, rsp_err=1, go RESP.
REQ-017 Ack and timeout in the same cycle: ack wins (normal completion, rsp_err=0).
REQ-018 wbm_ack_i in IDLE or RESP is ignored; no state change, no data capture.
REQ-019 RESP: rsp_dat/rsp_err held stable until rsp_valid&rsp_ready; then IDLE, cmd_ready high the next cycle; back-to-back commands are separated by at least one idle bus cycle.
REQ-020 wbm_we_o/adr_o/dat_o/sel_o retain last values after a cycle ends; only cyc/stb are returned to 0.
REQ-021 cmd_* inputs are sampled only at the accept edge; later changes have no effect.

Reset
REQ-022 wb_rst_i high at an edge: state=IDLE, cyc_o=stb_o=we_o=0, sel_o=4'h0, adr_o=dat_o=32'h0, rsp_dat=32'h0, rsp_err=0, counter=0.
REQ-023 Reset mid-BUS drops cyc/stb at that edge; the in-flight transaction produces no response.
REQ-024 Reset mid-RESP discards the pending response; rsp_valid=0 from the next cycle.

Configuration
REQ-025 Macro WBM_TIMEOUT_EN defined: timeout counter and REQ-016/REQ-017 behaviour present.
REQ-026 Macro WBM_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for ack; rsp_err tied 0; TIMEOUT and ERR_DATA unused.

Verification
REQ-027 Write cmd adr 32'h3000_0001, dat 32'h1, sel 4'hF; ack 1 cycle later -> one cyc/stb/we pulse with those values, rsp_valid with rsp_dat=0, rsp_err=0.
REQ-028 Read cmd adr 32'h3100_0002; responder acks after 3 wait cycles with 32'hDEAD_BEEF -> cyc/stb high 4 cycles, rsp_dat=32'hDEAD_BEEF.
REQ-029 (WBM_TIMEOUT_EN, TIMEOUT=8) read 32'h3200_000E, no ack -> cyc/stb drop after 8 cycles, rsp_err=1, rsp_dat=32'hDEAD_DEAD; ack arriving exactly on cycle 8 -> normal completion.
REQ-030 rsp_ready held low 5 cycles -> rsp_valid and rsp_dat stable, cmd_ready low throughout, next cmd_valid not accepted.
REQ-031 wb_rst_i pulsed 1 cycle during BUS of write 32'h3400_0001 -> cyc/stb low at the next edge, no rsp_valid, cmd_ready high after reset; stray ack in IDLE ignored.
